// File: rtl/conv_window_sequencer.sv
// Sequences one 1-D convolution pass: per window clear, tap reads, drain, psum handoff.
// Optional CONV_SEQ_PERF_EN adds a saturating stall-cycle counter output.
module conv_window_sequencer #(
  parameter int unsigned FW = 5,
  parameter int unsigned AW = 6,
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [FW-1:0] filter_size,
  input  logic [SW-1:0] stride,
  input  logic [AW-1:0] ifmap_len,
  input  logic          ifmap_avail,
  output logic          cnt_en,
  input  logic [FW-1:0] i_count,
  input  logic          go_next_stride,
  output logic [AW-1:0] ifmap_raddr,
  output logic [FW-1:0] filt_raddr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          psum_valid,
  input  logic          psum_ready,
  output logic [AW-1:0] psum_idx,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [15:0]   perf_stall_cycles
`endif
);

  localparam int unsigned NW = AW + 1;
  localparam int unsigned XW = ((FW > AW) ? FW : AW) + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  logic [FW-1:0] cfg_fs;
  logic [SW-1:0] cfg_stride;
  logic [AW-1:0] cfg_len;
  logic [AW-1:0] base;
  logic [NW-1:0] next_base;
  logic          cfg_bad;
  logic          last_window;
  logic          start_ok;

  // Counter enable must track ifmap_avail in the same cycle, so it is a direct decode.
  assign cnt_en      = (state == S_MAC) && ifmap_avail;
  assign ifmap_raddr = base + AW'(i_count);
  assign filt_raddr  = i_count;

  assign cfg_bad     = (filter_size < FW'(2)) || (stride == '0) ||
                       (XW'(filter_size) > XW'(ifmap_len));
  assign start_ok    = (state == S_IDLE) && start && !cfg_bad;
  assign next_base   = NW'(base) + NW'(cfg_stride);
  // Window end test without division: stop once the next window would overrun the ifmap.
  assign last_window = (XW'(next_base) + XW'(cfg_fs)) > XW'(cfg_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_fs     <= '0;
      cfg_stride <= '0;
      cfg_len    <= '0;
      base       <= '0;
      psum_idx   <= '0;
      acc_clr    <= 1'b0;
      acc_en     <= 1'b0;
      psum_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      acc_en  <= cnt_en;
      acc_clr <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_fs     <= filter_size;
              cfg_stride <= stride;
              cfg_len    <= ifmap_len;
              base       <= '0;
              psum_idx   <= '0;
              acc_clr    <= 1'b1;
              busy       <= 1'b1;
              state      <= S_CLR;
            end
          end
        end
        S_CLR: state <= S_MAC;
        S_MAC: begin
          if (cnt_en && go_next_stride) state <= S_DRAIN;
        end
        S_DRAIN: begin
          psum_valid <= 1'b1;
          state      <= S_WRITE;
        end
        S_WRITE: begin
          if (psum_ready) begin
            psum_valid <= 1'b0;
            if (last_window) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              base     <= next_base[AW-1:0];
              psum_idx <= psum_idx + AW'(1);
              acc_clr  <= 1'b1;
              state    <= S_CLR;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  // Stall cycles: MAC waiting on the ifmap, WRITE waiting on downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
    end else if (start_ok) begin
      perf_stall_cycles <= '0;
    end else if (((state == S_MAC) && !ifmap_avail) || ((state == S_WRITE) && !psum_ready)) begin
      if (perf_stall_cycles != 16'hFFFF) perf_stall_cycles <= perf_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized self-checking bench for conv_window_sequencer with a transaction-level model.
// Define CONV_SEQ_PERF_EN to also check perf_stall_cycles.
module tb_conv_window_sequencer;

  localparam int unsigned FW = 5;
  localparam int unsigned AW = 6;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [FW-1:0] filter_size;
  logic [SW-1:0] stride;
  logic [AW-1:0] ifmap_len;
  logic          ifmap_avail;
  logic          cnt_en;
  logic [FW-1:0] i_cnt;
  logic          go_next_stride;
  logic [AW-1:0] ifmap_raddr;
  logic [FW-1:0] filt_raddr;
  logic          acc_clr;
  logic          acc_en;
  logic          psum_valid;
  logic          psum_ready;
  logic [AW-1:0] psum_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef CONV_SEQ_PERF_EN
  logic [15:0]   perf_stall_cycles;
`endif

  logic [FW-1:0] cur_fs = '0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_window_sequencer #(.FW(FW), .AW(AW), .SW(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .filter_size    (filter_size),
    .stride         (stride),
    .ifmap_len      (ifmap_len),
    .ifmap_avail    (ifmap_avail),
    .cnt_en         (cnt_en),
    .i_count        (i_cnt),
    .go_next_stride (go_next_stride),
    .ifmap_raddr    (ifmap_raddr),
    .filt_raddr     (filt_raddr),
    .acc_clr        (acc_clr),
    .acc_en         (acc_en),
    .psum_valid     (psum_valid),
    .psum_ready     (psum_ready),
    .psum_idx       (psum_idx),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
`ifdef CONV_SEQ_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Environment model of the filter-index counter that shares rst with the sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) i_cnt <= '0;
    else if (cnt_en) i_cnt <= (i_cnt == cur_fs - FW'(1)) ? '0 : i_cnt + FW'(1);
  end
  assign go_next_stride = (i_cnt == cur_fs - FW'(1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, psum_valid, 0);
    check({tag, "_acc_en"}, acc_en, 0);
    check({tag, "_acc_clr"}, acc_clr, 0);
    check({tag, "_cnt_en"}, cnt_en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_psum_idx"}, psum_idx, 0);
    check({tag, "_raddr"}, ifmap_raddr, 0);
  endtask

  task automatic drive_random(input int avail_pct, input int ready_pct);
    ifmap_avail = ($urandom_range(99) < avail_pct);
    psum_ready  = ($urandom_range(99) < ready_pct);
  endtask

  // One pass; abort_win >= 0 asserts rst on the first tap of that window.
  task automatic run_pass(input int fs, input int st, input int len,
                          input int avail_pct, input int ready_pct, input int abort_win);
    int  exp_n, k, tap, accs, last_hs, stall_m;
    bit  in_mac, prev_wait, clr_seen, finished;
    logic [AW-1:0] prev_idx;
    exp_n = (len - fs) / st + 1;
    k = 0; tap = 0; accs = 0; last_hs = 0; stall_m = 0;
    in_mac = 0; prev_wait = 0; clr_seen = 0; finished = 0; prev_idx = '0;
    @(negedge clk);
    filter_size = FW'(fs); stride = SW'(st); ifmap_len = AW'(len); start = 1'b1;
    cur_fs = FW'(fs);
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      drive_random(avail_pct, ready_pct);
      if (cyc == 2) begin
        start = 1'b1; stride = '0;
      end
      @(negedge clk);
      if (cyc == 0) check("start_accepted", cfg_err, 0);
      if (cyc == 3) check("start_ignored_busy", cfg_err, 0);
      if (in_mac && !ifmap_avail) stall_m++;
      if (psum_valid && !psum_ready) stall_m++;
      if (prev_wait) begin
        check("valid_hold", psum_valid, 1);
        check("idx_hold", psum_idx, prev_idx);
      end
      if (psum_valid) check("no_cnt_in_write", cnt_en, 0);
      if (acc_en) accs++;
      if (cnt_en) begin
        check("cnt_en_avail", ifmap_avail, 1);
        if (tap == 0) check("clr_before_window", clr_seen, 1);
        check("ifmap_raddr", ifmap_raddr, k * st + tap);
        check("filt_raddr", filt_raddr, tap);
        if (abort_win == k) begin
          rst = 1'b1;
          #1 check_idle_outputs("abort");
          @(negedge clk) rst = 1'b0;
          return;
        end
        tap++;
        clr_seen = 0;
      end
      if (psum_valid && psum_ready) begin
        check("psum_idx", psum_idx, k);
        check("taps_per_window", tap, fs);
        check("acc_en_per_window", accs, fs);
        if (avail_pct == 100 && ready_pct == 100 && k > 0)
          check("window_cycles", cyc - last_hs, fs + 3);
        last_hs = cyc; k++; tap = 0; accs = 0;
      end
      if (cnt_en && go_next_stride) in_mac = 0;
      if (acc_clr) begin
        in_mac = 1; clr_seen = 1;
      end
      prev_wait = psum_valid && !psum_ready;
      prev_idx  = psum_idx;
      if (done) begin
        check("psum_count", k, exp_n);
        check("busy_at_done", busy, 1);
        finished = 1;
      end
      @(posedge clk); #1 start = 1'b0;
    end
    if (!finished) begin
      check("pass_timeout", 0, 1);
    end else begin
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_single", done, 0);
`ifdef CONV_SEQ_PERF_EN
      check("perf_stall_cycles", perf_stall_cycles, stall_m);
`endif
    end
  endtask

  task automatic cfg_reject(input int fs, input int st, input int len);
    @(negedge clk);
    filter_size = FW'(fs); stride = SW'(st); ifmap_len = AW'(len); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    @(negedge clk);
    check("cfg_err_single", cfg_err, 0);
    check("cfg_err_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; filter_size = '0; stride = '0; ifmap_len = '0;
    ifmap_avail = 1'b0; psum_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
`ifdef CONV_SEQ_PERF_EN
    check("reset_perf", perf_stall_cycles, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", busy, 0);

    run_pass(3, 1, 5, 100, 100, -1);
    run_pass(3, 2, 8, 100, 100, -1);
    cfg_reject(1, 1, 8);
    cfg_reject(3, 0, 8);
    cfg_reject(9, 1, 8);
    run_pass(3, 1, 8, 60, 40, -1);
    run_pass(3, 1, 8, 100, 100, 1);
    run_pass(3, 1, 5, 100, 100, -1);
    run_pass(2, 7, 63, 70, 70, -1);
    run_pass(31, 3, 31, 80, 60, -1);

    for (int i = 0; i < 10; i++) begin
      int len, fs, st;
      len = $urandom_range(40, 2);
      fs  = $urandom_range((len < 31) ? len : 31, 2);
      st  = $urandom_range(7, 1);
      run_pass(fs, st, len, $urandom_range(100, 50), $urandom_range(100, 50), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
